stack_bus_upstream_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one stack bus upstream channel among several requesters (manager or PE lanes) in a stack slice. It sits between the requester lanes and the stack bus upstream port and holds a grant from start-of-packet to end-of-packet. Source ID travels with every beat, and the output is a registered stage with full-throughput backpressure.

---
 rtl/stack_bus_arb_pkg.sv | 23 ++
 rtl/stack_bus_rr_arbiter.sv | 33 +++
 rtl/stack_bus_upstream_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_stack_bus_upstream_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_bus_arb_pkg.sv
// Shared control encodings, arbiter state type and defaults for the stack bus
// upstream arbiter.
package stack_bus_arb_pkg;

  localparam int STK_CNTL_W = 2;

  localparam logic [1:0] STK_CNTL_MOP     = 2'b00;
  localparam logic [1:0] STK_CNTL_SOP     = 2'b01;
  localparam logic [1:0] STK_CNTL_EOP     = 2'b10;
  localparam logic [1:0] STK_CNTL_SOP_EOP = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  function automatic logic is_eop(input logic [STK_CNTL_W-1:0] cntl);
    return (cntl == STK_CNTL_EOP) || (cntl == STK_CNTL_SOP_EOP);
  endfunction

endpackage

// File: rtl/stack_bus_rr_arbiter.sv
// Combinational rotate-priority pick: the first valid requester at or above
// rr_ptr (with wrap-around) wins.
module stack_bus_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  int   pos_s;
  logic hit_s;

  // Walk requesters in priority order; once one hits, later ones are masked.
  always_comb begin
    grant_oh  = {NUM_REQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    any_valid = 1'b0;
    pos_s     = 0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s           = (int'(rr_ptr) + k) % NUM_REQ;
      hit_s           = valid[pos_s] && !any_valid;
      grant_oh[pos_s] = hit_s;
      grant_idx       = hit_s ? ID_W'(pos_s) : grant_idx;
      any_valid       = any_valid || hit_s;
    end
  end

endmodule

// File: rtl/stack_bus_upstream_arbiter.sv
// Packet-granular round-robin arbiter onto the stack bus upstream channel with a
// registered output stage. Optional watchdog: STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN.
module stack_bus_upstream_arbiter
  import stack_bus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 64,
  parameter int CNTL_W         = STK_CNTL_W,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_REQ-1:0]        req__arb__valid,
  input  logic [NUM_REQ*CNTL_W-1:0] req__arb__cntl,
  input  logic [NUM_REQ*DATA_W-1:0] req__arb__data,
  output logic [NUM_REQ-1:0]        arb__req__ready,
  output logic                      arb__stk__valid,
  output logic [CNTL_W-1:0]         arb__stk__cntl,
  output logic [DATA_W-1:0]         arb__stk__data,
  output logic [ID_W-1:0]           arb__stk__id,
  input  logic                      stk__arb__ready,
  output logic                      arb__sys__timeout
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [CNTL_W-1:0]   out_cntl_q, out_cntl_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [ID_W-1:0]     pick_idx_s;
  logic                any_valid_s;
  logic [CNTL_W-1:0]   sel_cntl_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                sel_eop_s;
  logic                slot_free_s;
  logic                accept_s;
  logic [ID_W-1:0]     grant_next_s;

`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  stack_bus_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid     (req__arb__valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s),
    .any_valid (any_valid_s)
  );

  assign sel_cntl_s   = req__arb__cntl[grant_q*CNTL_W +: CNTL_W];
  assign sel_data_s   = req__arb__data[grant_q*DATA_W +: DATA_W];
  assign sel_eop_s    = is_eop(sel_cntl_s);
  assign slot_free_s  = !out_valid_q || stk__arb__ready;
  assign grant_next_s = (grant_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_q + 1'b1;

  // Only the granted requester sees ready, and only while the output slot can take a beat.
  always_comb begin
    if (state_q == XFER) begin
      arb__req__ready = slot_free_s ? grant_oh_q : {NUM_REQ{1'b0}};
    end else begin
      arb__req__ready = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration FSM, grant bookkeeping and output-register update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_cntl_d  = out_cntl_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    timeout_d   = 1'b0;
    accept_s    = 1'b0;
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid_s) begin
          state_d    = XFER;
          grant_d    = pick_idx_s;
          grant_oh_d = pick_oh_s;
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
          to_cnt_d   = {TO_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        accept_s = req__arb__valid[grant_q] && slot_free_s;
        if (accept_s) begin
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
          to_cnt_d = {TO_W{1'b0}};
`endif
          if (sel_eop_s) begin
            rr_ptr_d = grant_next_s;
            state_d  = IDLE;
          end else begin
            state_d = XFER;
          end
        end else begin
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
          // The pulse is registered, so fire on the cycle the count would reach the limit.
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            rr_ptr_d  = grant_next_s;
            state_d   = IDLE;
            to_cnt_d  = {TO_W{1'b0}};
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`else
          state_d = XFER;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_cntl_d  = sel_cntl_s;
      out_data_d  = sel_data_s;
      out_id_d    = grant_q;
    end else if (out_valid_q && stk__arb__ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q     <= IDLE;
      grant_q     <= {ID_W{1'b0}};
      grant_oh_q  <= {NUM_REQ{1'b0}};
      rr_ptr_q    <= {ID_W{1'b0}};
      out_valid_q <= 1'b0;
      out_cntl_q  <= {CNTL_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_id_q    <= {ID_W{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_cntl_q  <= out_cntl_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
  // Stall watchdog counter.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      to_cnt_q <= {TO_W{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign arb__stk__valid   = out_valid_q;
  assign arb__stk__cntl    = out_cntl_q;
  assign arb__stk__data    = out_data_q;
  assign arb__stk__id      = out_id_q;
  assign arb__sys__timeout = timeout_q;

endmodule

// File: tb/tb_stack_bus_upstream_arbiter.sv
// Self-checking bench: packet-level round-robin reference model plus directed
// timing scenarios for the stack bus upstream arbiter.
module tb_stack_bus_upstream_arbiter;
  import stack_bus_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int CNTL_W  = 2;
  localparam int ID_W    = 2;

  typedef struct packed { logic [1:0] cntl; logic [63:0] data; } beat_t;
  typedef struct packed { logic [1:0] id; logic [1:0] cntl; logic [63:0] data; } obs_t;

  logic                      clk = 1'b0;
  logic                      reset_poweron;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*CNTL_W-1:0] req_cntl;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        arb_ready;
  logic                      stk_valid;
  logic [CNTL_W-1:0]         stk_cntl;
  logic [DATA_W-1:0]         stk_data;
  logic [ID_W-1:0]           stk_id;
  logic                      stk_ready;
  logic                      sys_timeout;

  always #5 clk = ~clk;

  stack_bus_upstream_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNTL_W(CNTL_W), .ID_W(ID_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk               (clk),
    .reset_poweron     (reset_poweron),
    .req__arb__valid   (req_valid),
    .req__arb__cntl    (req_cntl),
    .req__arb__data    (req_data),
    .arb__req__ready   (arb_ready),
    .arb__stk__valid   (stk_valid),
    .arb__stk__cntl    (stk_cntl),
    .arb__stk__data    (stk_data),
    .arb__stk__id      (stk_id),
    .stk__arb__ready   (stk_ready),
    .arb__sys__timeout (sys_timeout)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ref_ptr = 0;
  beat_t drv_q[NUM_REQ][$];
  beat_t mdl_q[NUM_REQ][$];
  obs_t  exp_q[$];
  obs_t  obs_q[$];
  int    obs_cyc[$];
  bit    en[NUM_REQ];
  bit    in_pkt[NUM_REQ];
  int    rdy_cyc[NUM_REQ];
  bit    gap_en = 1'b0;
  bit    bp_en = 1'b0;
  bit    stk_hold_low = 1'b0;
  int    to_pulses = 0;

  // One clock: drive at negedge, sample just after, account handshakes for the next posedge.
  task automatic cycle();
    logic [NUM_REQ-1:0] v;
    beat_t hd;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = en[i] && (drv_q[i].size() > 0) && !(gap_en && in_pkt[i] && ($urandom_range(0, 3) == 0));
      hd = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
      req_valid[i] = v[i];
      req_cntl[i*CNTL_W +: CNTL_W] = v[i] ? hd.cntl : 2'b00;
      req_data[i*DATA_W +: DATA_W] = v[i] ? hd.data : 64'd0;
    end
    stk_ready = stk_hold_low ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
    #1;
    checks++;
    if ((arb_ready & (arb_ready - 4'd1)) != 4'd0) begin
      errors++; $display("FAIL ready_onehot cyc=%0d: got %b, required at most one bit", cyc, arb_ready);
    end
    checks++;
    if (stk_valid && !stk_ready && arb_ready != 4'd0) begin
      errors++; $display("FAIL ready_backpressure cyc=%0d: got %b, required 0000", cyc, arb_ready);
    end
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
    if (sys_timeout) to_pulses++;
`else
    checks++;
    if (sys_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_tied cyc=%0d: got %b, required 0", cyc, sys_timeout);
    end
`endif
    if (stk_valid && stk_ready) begin
      obs_q.push_back({stk_id, stk_cntl, stk_data});
      obs_cyc.push_back(cyc);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_ready[i] && rdy_cyc[i] < 0) rdy_cyc[i] = cyc;
      if (v[i] && arb_ready[i]) begin
        hd = drv_q[i].pop_front();
        in_pkt[i] = !is_eop(hd.cntl);
      end
    end
    cyc++;
  endtask

  task automatic clear_logs();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      rdy_cyc[i] = -1; en[i] = 1'b1; in_pkt[i] = 1'b0;
      drv_q[i].delete(); mdl_q[i].delete();
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom(), $urandom()};
      if (len == 1)          b.cntl = STK_CNTL_SOP_EOP;
      else if (k == 0)       b.cntl = STK_CNTL_SOP;
      else if (k == len - 1) b.cntl = STK_CNTL_EOP;
      else                   b.cntl = STK_CNTL_MOP;
      drv_q[r].push_back(b);
      mdl_q[r].push_back(b);
    end
  endtask

  // Reference: whole packets leave in round-robin order over requesters with work queued.
  task automatic model_order(inout int ptr);
    bit done = 1'b0;
    int pick;
    int r;
    beat_t b;
    logic [1:0] id2;
    while (!done) begin
      pick = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        r = (ptr + k) % NUM_REQ;
        if (pick < 0 && mdl_q[r].size() > 0) pick = r;
      end
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        id2 = pick[1:0];
        do begin
          b = mdl_q[pick].pop_front();
          exp_q.push_back({id2, b.cntl, b.data});
        end while (!is_eop(b.cntl));
        ptr = (pick + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin cycle(); c++; end
    checks++;
    if (obs_q.size() < n) begin
      errors++; $display("FAIL %s_budget: got %0d beats, required %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d beats, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s[%0d]: got id=%0d cntl=%0d data=%h, required id=%0d cntl=%0d data=%h", name, k,
                 obs_q[k].id, obs_q[k].cntl, obs_q[k].data, exp_q[k].id, exp_q[k].cntl, exp_q[k].data);
      end
    end
  endtask

  task automatic test_reset();
    reset_poweron = 1'b0;
    req_valid = 4'hF; req_cntl = 8'hFF; req_data = {8{$urandom()}}; stk_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks += 6;
    if (stk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", stk_valid); end
    if (stk_cntl !== 2'd0) begin errors++; $display("FAIL reset_cntl: got %0d, required 0", stk_cntl); end
    if (stk_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", stk_data); end
    if (stk_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d, required 0", stk_id); end
    if (arb_ready !== 4'd0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", arb_ready); end
    if (sys_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", sys_timeout); end
    req_valid = 4'd0; req_cntl = 8'd0; req_data = '0;
    reset_poweron = 1'b1;
    ref_ptr = 0;
  endtask

  task automatic test_rr_order();
    clear_logs();
    for (int p = 0; p < 2; p++) for (int i = 0; i < NUM_REQ; i++) add_pkt(i, 1);
    model_order(ref_ptr);
    run_until(8, 100, "rr_order");
    compare_stream("rr_order");
    for (int k = 1; k < obs_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[k] - obs_cyc[k-1] != 2) begin
        errors++; $display("FAIL rr_bubble[%0d]: got spacing %0d, required 2", k, obs_cyc[k] - obs_cyc[k-1]);
      end
    end
  endtask

  task automatic test_latency();
    int start;
    clear_logs();
    add_pkt(2, 3);
    model_order(ref_ptr);
    start = cyc;
    run_until(3, 20, "latency");
    compare_stream("latency");
    checks++;
    if (rdy_cyc[2] != start + 1) begin
      errors++; $display("FAIL latency_ready: got cycle %0d, required %0d", rdy_cyc[2], start + 1);
    end
    for (int k = 0; k < obs_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[k] != start + 2 + k) begin
        errors++; $display("FAIL latency_beat[%0d]: got cycle %0d, required %0d", k, obs_cyc[k], start + 2 + k);
      end
    end
    clear_logs();
    add_pkt(0, 1); add_pkt(3, 1);
    model_order(ref_ptr);
    run_until(2, 20, "rr_ptr");
    compare_stream("rr_ptr");
    checks++;
    if (obs_q.size() > 0 && obs_q[0].id !== 2'd3) begin
      errors++; $display("FAIL rr_ptr_after_eop: got id %0d, required 3", obs_q[0].id);
    end
  endtask

  task automatic test_hold_grant();
    clear_logs();
    gap_en = 1'b1;
    add_pkt(0, 4);
    model_order(ref_ptr);
    en[3] = 1'b0;
    add_pkt(3, 2);
    model_order(ref_ptr);
    for (int b = 0; b < 20 && !in_pkt[0]; b++) cycle();
    en[3] = 1'b1;
    run_until(6, 80, "hold_grant");
    compare_stream("hold_grant");
    gap_en = 1'b0;
  endtask

  task automatic test_backpressure();
    clear_logs();
    add_pkt(1, 4);
    model_order(ref_ptr);
    run_until(2, 20, "bp_pre");
    stk_hold_low = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cycle();
      checks += 3;
      if (stk_valid !== 1'b1 || stk_id !== 2'd1) begin
        errors++; $display("FAIL bp_hold_valid[%0d]: got valid=%b id=%0d, required valid=1 id=1", s, stk_valid, stk_id);
      end
      if (stk_data !== exp_q[2].data) begin
        errors++; $display("FAIL bp_hold_data[%0d]: got %h, required %h", s, stk_data, exp_q[2].data);
      end
      if (arb_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b, required 0", s, arb_ready[1]);
      end
    end
    stk_hold_low = 1'b0;
    run_until(4, 20, "bp_post");
    repeat (4) cycle();
    compare_stream("backpressure");
  endtask

  task automatic test_reset_mid_packet();
    logic pre_valid;
    clear_logs();
    add_pkt(3, 4); add_pkt(1, 1);
    run_until(2, 30, "rst_pre");
    pre_valid = stk_valid;
    #1 reset_poweron = 1'b0;
    req_valid = 4'd0;
    #1;
    checks += 5;
    if (pre_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b, required 1", pre_valid); end
    if (stk_valid !== 1'b0 || stk_id !== 2'd0) begin
      errors++; $display("FAIL rst_async_valid_id: got valid=%b id=%0d, required 0 0", stk_valid, stk_id);
    end
    if (stk_cntl !== 2'd0) begin errors++; $display("FAIL rst_async_cntl: got %0d, required 0", stk_cntl); end
    if (stk_data !== 64'd0) begin errors++; $display("FAIL rst_async_data: got %h, required 0", stk_data); end
    if (arb_ready !== 4'd0) begin errors++; $display("FAIL rst_async_ready: got %b, required 0000", arb_ready); end
    clear_logs();
    repeat (2) @(negedge clk);
    reset_poweron = 1'b1;
    ref_ptr = 0;
    add_pkt(1, 1); add_pkt(3, 1);
    model_order(ref_ptr);
    run_until(2, 20, "rst_post");
    compare_stream("rst_post");
    checks++;
    if (obs_q.size() > 0 && obs_q[0].id !== 2'd1) begin
      errors++; $display("FAIL grant_after_reset: got id %0d, required 1", obs_q[0].id);
    end
  endtask

`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    to_pulses = 0;
    add_pkt(1, 3); add_pkt(2, 1);
    for (int b = 0; b < 20 && !in_pkt[1]; b++) cycle();
    en[1] = 1'b0;
    run_until(2, 60, "timeout");
    repeat (12) cycle();
    checks += 2;
    if (to_pulses != 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses, required 1", to_pulses); end
    if (obs_q.size() != 2 || obs_q[0].id !== 2'd1 || obs_q[1].id !== 2'd2 || obs_q[1].cntl !== STK_CNTL_SOP_EOP) begin
      errors++; $display("FAIL timeout_next_grant: got %0d beats, required SOP from 1 then SOP_EOP from 2", obs_q.size());
    end
    clear_logs();
    ref_ptr = 3;
  endtask
`endif

  task automatic test_random();
    gap_en = 1'b1; bp_en = 1'b1;
    for (int round = 0; round < 6; round++) begin
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 4));
      end
      model_order(ref_ptr);
      run_until(exp_q.size(), 400, "random");
      repeat (4) cycle();
      compare_stream("random");
    end
    gap_en = 1'b0; bp_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_order();
    test_latency();
    test_hold_grant();
    test_backpressure();
    test_reset_mid_packet();
`ifdef STACK_BUS_UPSTREAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
